// File: rtl/gcd_pkg.sv
// Shared definitions for the parametrised GCD engine.
// Holds the default operand width and the controller state encoding.
// Encoding 2'd3 is unused; the controller treats it as IDLE.
package gcd_pkg;

    localparam int GCD_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_param_dp.sv
// Datapath of the GCD engine: the x/y operand registers, the subtractor
// and the comparator flags used by the controller.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   load            - capture x_in/y_in into the operand registers
//   sub_x / sub_y   - replace x with x-y, or y with y-x
//   x_in, y_in      - operands presented by the requester
//   x_val, y_val    - current operand register contents
//   x_zero, y_zero  - operand register equals zero
//   eq, gt          - x equals y, x greater than y (unsigned)
module gcd_param_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             sub_x,
    input  logic             sub_y,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] x_val,
    output logic [WIDTH-1:0] y_val,
    output logic             x_zero,
    output logic             y_zero,
    output logic             eq,
    output logic             gt
);

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    // The controller only asserts sub_x when x > y and sub_y when y > x,
    // so the larger operand is always the minuend and nothing underflows.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load) begin
            x_d = x_in;
            y_d = y_in;
        end else if (sub_x) begin
            x_d = x_q - y_q;
        end else if (sub_y) begin
            y_d = y_q - x_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_val  = x_q;
    assign y_val  = y_q;
    assign x_zero = (x_q == '0);
    assign y_zero = (y_q == '0);
    assign eq     = (x_q == y_q);
    assign gt     = (x_q > y_q);

endmodule

// File: rtl/gcd_param_fsmd.sv
// Parametrised GCD engine using repeated subtraction.
// A start seen in IDLE or DONE captures x_in/y_in and begins a run; busy
// stays high while computing, then gcd_out is presented with gcd_done held
// high until the next accepted start or reset.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset, overrides everything
//   start      - run request, only looked at in IDLE or DONE
//   x_in, y_in - operands, captured on the accepting edge
//   gcd_out    - result, valid while gcd_done is high
//   gcd_done   - result-valid level
//   busy       - high while the run is in progress
//   iter_count - number of subtractions in the last run
//                (only present when GCD_ITER_COUNT_EN is defined)
//
// Optional feature macro: GCD_ITER_COUNT_EN
module gcd_param_fsmd
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] gcd_out,
    output logic             gcd_done,
    output logic             busy
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_count
`endif
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] gcd_out_q, gcd_out_d;
    logic             gcd_done_q, gcd_done_d;
    logic             busy_q, busy_d;

    logic             load;
    logic             sub_x;
    logic             sub_y;
    logic [WIDTH-1:0] x_val;
    logic [WIDTH-1:0] y_val;
    logic             x_zero;
    logic             y_zero;
    logic             eq;
    logic             gt;

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] iter_count_q, iter_count_d;
`endif

    gcd_param_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .sub_x  (sub_x),
        .sub_y  (sub_y),
        .x_in   (x_in),
        .y_in   (y_in),
        .x_val  (x_val),
        .y_val  (y_val),
        .x_zero (x_zero),
        .y_zero (y_zero),
        .eq     (eq),
        .gt     (gt)
    );

    // Next-state and control logic. A zero operand finishes immediately with
    // the other operand as the result; that also covers gcd(0,0)=0.
    always_comb begin
        state_d    = state_q;
        gcd_out_d  = gcd_out_q;
        gcd_done_d = gcd_done_q;
        busy_d     = busy_q;
        load       = 1'b0;
        sub_x      = 1'b0;
        sub_y      = 1'b0;
`ifdef GCD_ITER_COUNT_EN
        iter_d       = iter_q;
        iter_count_d = iter_count_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    busy_d     = 1'b1;
                    gcd_done_d = 1'b0;
                    state_d    = CALC;
`ifdef GCD_ITER_COUNT_EN
                    iter_d = '0;
`endif
                end
            end
            CALC: begin
                if (x_zero || y_zero || eq) begin
                    gcd_out_d  = x_zero ? y_val : x_val;
                    gcd_done_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
`ifdef GCD_ITER_COUNT_EN
                    iter_count_d = iter_q;
`endif
                end else begin
                    sub_x = gt;
                    sub_y = ~gt;
`ifdef GCD_ITER_COUNT_EN
                    iter_d = iter_q + {{(WIDTH-1){1'b0}}, 1'b1};
`endif
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                gcd_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gcd_out_q  <= '0;
            gcd_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gcd_out_q  <= gcd_out_d;
            gcd_done_q <= gcd_done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef GCD_ITER_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q       <= '0;
            iter_count_q <= '0;
        end else begin
            iter_q       <= iter_d;
            iter_count_q <= iter_count_d;
        end
    end

    assign iter_count = iter_count_q;
`endif

    assign gcd_out  = gcd_out_q;
    assign gcd_done = gcd_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_gcd_param_fsmd.sv
// Testbench for gcd_param_fsmd at WIDTH=8. Expected results come from a
// Euclid-division reference: the gcd is the last non-zero remainder and the
// number of subtractions is the sum of the quotients minus one.
module tb_gcd_param_fsmd;

    localparam int WIDTH  = 8;
    localparam int BUDGET = 300;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] gcd_out;
    logic             gcd_done;
    logic             busy;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_count;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    gcd_param_fsmd #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .gcd_out    (gcd_out),
        .gcd_done   (gcd_done),
        .busy       (busy)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count (iter_count)
`endif
    );

    // Free-running clock; inputs are driven and outputs sampled on the
    // falling edge so nothing races the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Last-resort guard so the run can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: gcd and subtraction count from Euclidean division.
    function automatic void ref_gcd(input int a, input int b, output int g, output int n);
        int p, q, r;
        n = 0;
        if (a == 0 || b == 0) begin
            g = a + b;
            return;
        end
        p = (a > b) ? a : b;
        q = (a > b) ? b : a;
        while (q != 0) begin
            n = n + p / q;
            r = p % q;
            p = q;
            q = r;
        end
        g = p;
        n = n - 1;
    endfunction

    // Pulses start for one edge (E0); returns at the falling edge after E0.
    task automatic do_start(input int a, input int b);
        start = 1'b1;
        x_in  = WIDTH'(a);
        y_in  = WIDTH'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for gcd_done, counting edges; scrambles operands meanwhile.
    // busy_bad flags busy low before done, or busy high together with done.
    task automatic wait_done(output int cycles, output bit busy_bad);
        cycles   = 0;
        busy_bad = 1'b0;
        while (gcd_done !== 1'b1 && cycles < BUDGET) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            x_in = WIDTH'($urandom);
            y_in = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        if (gcd_done === 1'b1 && busy !== 1'b0) busy_bad = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
        end
        n_compared++;
        if (gcd_done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_done: got %0b expected 0", gcd_done);
        end
        n_compared++;
        if (gcd_out !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_gcd_out: got %0d expected 0", gcd_out);
        end
`ifdef GCD_ITER_COUNT_EN
        n_compared++;
        if (iter_count !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_iter: got %0d expected 0", iter_count);
        end
`endif
    endtask

    task automatic test_directed();
        int  xs [4] = '{14, 0, 0, 255};
        int  ys [4] = '{6, 9, 0, 1};
        int  g, n, cycles;
        bit  busy_bad;
        for (int i = 0; i < 4; i++) begin
            ref_gcd(xs[i], ys[i], g, n);
            do_start(xs[i], ys[i]);
            n_compared++;
            if (busy !== 1'b1 || gcd_done !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL directed_accept[%0d]: got busy=%0b done=%0b expected busy=1 done=0",
                         i, busy, gcd_done);
            end
            wait_done(cycles, busy_bad);
            n_compared++;
            if (cycles != n + 1) begin
                n_mismatched++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, cycles, n + 1);
            end
            n_compared++;
            if (gcd_out !== WIDTH'(g)) begin
                n_mismatched++;
                $display("[TB] FAIL directed_gcd[%0d]: got %0d expected %0d", i, gcd_out, g);
            end
            n_compared++;
            if (busy_bad !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL directed_busy[%0d]: got busy_bad=%0b expected 0", i, busy_bad);
            end
`ifdef GCD_ITER_COUNT_EN
            n_compared++;
            if (iter_count !== WIDTH'(n)) begin
                n_mismatched++;
                $display("[TB] FAIL directed_iter[%0d]: got %0d expected %0d", i, iter_count, n);
            end
`endif
        end
    endtask

    task automatic test_start_ignored();
        int  g, n, cycles;
        bit  busy_bad;
        ref_gcd(12, 18, g, n);
        do_start(12, 18);
        @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_busy: got %0b expected 1", busy);
        end
        start = 1'b1;
        x_in  = WIDTH'(7);
        y_in  = WIDTH'(7);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cycles, busy_bad);
        n_compared++;
        if (cycles + 2 != n + 1) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_latency: got %0d expected %0d", cycles + 2, n + 1);
        end
        n_compared++;
        if (gcd_out !== WIDTH'(g)) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_gcd: got %0d expected %0d", gcd_out, g);
        end
        n_compared++;
        if (busy_bad !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ignore_busy_done: got busy_bad=%0b expected 0", busy_bad);
        end
    endtask

    task automatic test_restart_from_done();
        int  g, n, g_prev, n_prev, cycles;
        bit  busy_bad;
        ref_gcd(12, 18, g_prev, n_prev);
        ref_gcd(9, 6, g, n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (gcd_done !== 1'b1 || gcd_out !== WIDTH'(g_prev)) begin
            n_mismatched++;
            $display("[TB] FAIL restart_hold: got done=%0b out=%0d expected done=1 out=%0d",
                     gcd_done, gcd_out, g_prev);
        end
        do_start(9, 6);
        n_compared++;
        if (gcd_done !== 1'b0 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL restart_accept: got done=%0b busy=%0b expected done=0 busy=1",
                     gcd_done, busy);
        end
`ifdef GCD_ITER_COUNT_EN
        n_compared++;
        if (iter_count !== WIDTH'(n_prev)) begin
            n_mismatched++;
            $display("[TB] FAIL restart_iter_hold: got %0d expected %0d", iter_count, n_prev);
        end
`endif
        wait_done(cycles, busy_bad);
        n_compared++;
        if (cycles != n + 1) begin
            n_mismatched++;
            $display("[TB] FAIL restart_latency: got %0d expected %0d", cycles, n + 1);
        end
        n_compared++;
        if (gcd_out !== WIDTH'(g)) begin
            n_mismatched++;
            $display("[TB] FAIL restart_gcd: got %0d expected %0d", gcd_out, g);
        end
    endtask

    task automatic test_reset_mid_calc();
        int  g, n, cycles;
        bit  busy_bad;
        do_start(200, 3);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_compared++;
        if (busy !== 1'b0 || gcd_done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_flags: got busy=%0b done=%0b expected 0 0", busy, gcd_done);
        end
        n_compared++;
        if (gcd_out !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_gcd_out: got %0d expected 0", gcd_out);
        end
`ifdef GCD_ITER_COUNT_EN
        n_compared++;
        if (iter_count !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_iter: got %0d expected 0", iter_count);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0 || gcd_done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_idle: got busy=%0b done=%0b expected 0 0", busy, gcd_done);
        end
        ref_gcd(20, 8, g, n);
        do_start(20, 8);
        wait_done(cycles, busy_bad);
        n_compared++;
        if (cycles != n + 1 || gcd_out !== WIDTH'(g)) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_rerun: got cycles=%0d out=%0d expected cycles=%0d out=%0d",
                     cycles, gcd_out, n + 1, g);
        end
    endtask

    task automatic test_random();
        int  a, b, g, n, cycles, gap;
        bit  busy_bad;
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            ref_gcd(a, b, g, n);
            do_start(a, b);
            wait_done(cycles, busy_bad);
            n_compared++;
            if (cycles != n + 1 || gcd_out !== WIDTH'(g)) begin
                n_mismatched++;
                $display("[TB] FAIL random[%0d] gcd(%0d,%0d): got cycles=%0d out=%0d expected cycles=%0d out=%0d",
                         i, a, b, cycles, gcd_out, n + 1, g);
            end
            n_compared++;
            if (busy_bad !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL random_busy[%0d]: got busy_bad=%0b expected 0", i, busy_bad);
            end
`ifdef GCD_ITER_COUNT_EN
            n_compared++;
            if (iter_count !== WIDTH'(n)) begin
                n_mismatched++;
                $display("[TB] FAIL random_iter[%0d]: got %0d expected %0d", i, iter_count, n);
            end
`endif
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                @(negedge clk);
                n_compared++;
                if (gcd_done !== 1'b1 || gcd_out !== WIDTH'(g)) begin
                    n_mismatched++;
                    $display("[TB] FAIL random_hold[%0d]: got done=%0b out=%0d expected done=1 out=%0d",
                             i, gcd_done, gcd_out, g);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] gcd_param_fsmd bench, WIDTH=%0d", WIDTH);
        test_reset();
        test_directed();
        test_start_ignored();
        test_restart_from_done();
        test_reset_mid_calc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
